// File: rtl/sdrc_req_gen_q_pkg.sv
// rtl/sdrc_req_gen_q_pkg.sv - shared types and constants for the queued request generator
package sdrc_req_gen_q_pkg;

  localparam int SDR_REQ_ID_W = 4;
  localparam int COL_BASE     = 8;

  typedef enum logic [1:0] {
    REQ_IDLE   = 2'd0,
    REQ_LOAD   = 2'd1,
    REQ_ACTIVE = 2'd2
  } req_state_e;

endpackage

// File: rtl/sdrc_sync_fifo.sv
// rtl/sdrc_sync_fifo.sv - show-ahead synchronous fifo holding queued app requests
module sdrc_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_wr;
  logic          do_rd;

  // A write into a full fifo is taken when the head leaves in the same cycle.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;

endmodule

// File: rtl/sdrc_req_gen_q.sv
// rtl/sdrc_req_gen_q.sv - queued app request to bank_ctl chunk generator
module sdrc_req_gen_q
  import sdrc_req_gen_q_pkg::*;
#(
  parameter int APP_AW   = 30,
  parameter int APP_RW   = 9,
  parameter int REQ_ID_W = SDR_REQ_ID_W,
  parameter int BA_W     = 2,
  parameter int RA_W     = 13,
  parameter int Q_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [1:0]                 cfg_colbits,
  input  logic [APP_RW-1:0]          cfg_max_len,
  input  logic [1:0]                 sdr_width,
  input  logic                       sdr_init_done,
  input  logic                       req,
  input  logic [REQ_ID_W-1:0]        req_id,
  input  logic [APP_AW:0]            req_addr,
  input  logic [APP_AW-2:0]          req_addr_mask,
  input  logic [APP_RW-1:0]          req_len,
  input  logic                       req_wrap,
  input  logic                       req_wr_n,
  output logic                       req_ack,
  output logic [$clog2(Q_DEPTH):0]   q_level,
  output logic                       r2x_idle,
  output logic                       r2b_req,
  output logic [REQ_ID_W-1:0]        r2b_req_id,
  output logic                       r2b_start,
  output logic                       r2b_last,
  output logic                       r2b_wrap,
  output logic                       r2b_write,
  output logic [BA_W-1:0]            r2b_ba,
  output logic [RA_W-1:0]            r2b_raddr,
  output logic [11:0]                r2b_caddr,
  output logic [APP_RW-1:0]          r2b_len,
  input  logic                       b2r_ack
);

  localparam int AW = APP_AW + 1;
  localparam int LW = APP_RW + 1;
  localparam int PW = (LW > 13) ? LW : 13;
  localparam int EW = REQ_ID_W + 2 + APP_RW + 2 * AW;

  req_state_e           state, state_nxt;
  logic                 q_full, q_empty, push, pop, advance;
  logic [AW-1:0]        mask_ext;
  logic [EW-1:0]        q_wdata, q_rdata;
  logic [REQ_ID_W-1:0]  h_id;
  logic                 h_wr_n, h_wrap;
  logic [APP_RW-1:0]    h_len;
  logic [AW-1:0]        h_mask, h_addr;

  logic [AW-1:0]        cur_addr, cur_mask;
  logic [APP_RW-1:0]    rem_len;

  logic [AW-1:0]        nxt_addr, c_addr, col_mask;
  logic [APP_RW-1:0]    nxt_rem, c_rem, c_len;
  logic                 c_wrap, c_last;
  logic [3:0]           col_w;
  logic [5:0]           row_sh;
  logic [11:0]          c_caddr;
  logic [BA_W-1:0]      c_ba;
  logic [RA_W-1:0]      c_raddr;
  logic [PW-1:0]        page_full, page_lim;
  logic [LW-1:0]        page_rem, len_sel;

  assign req_ack  = req & ~q_full & sdr_init_done;
  assign push     = req_ack;
  assign pop      = (state == REQ_LOAD);
  assign advance  = (state == REQ_ACTIVE) & b2r_ack & ~r2b_last;
  assign r2b_req  = (state == REQ_ACTIVE);
  assign r2x_idle = q_empty & (state == REQ_IDLE) & ~req;

  // Narrow SDR widths address sub-word units, so the low mask bits are replicated.
  always_comb begin
    mask_ext = '0;
    case (sdr_width)
      2'b00:   mask_ext = AW'(req_addr_mask);
      2'b01:   mask_ext = AW'({req_addr_mask, req_addr_mask[0]});
      default: mask_ext = AW'({req_addr_mask, req_addr_mask[1:0]});
    endcase
  end

  assign q_wdata = {req_id, req_wr_n, req_wrap, req_len, mask_ext, req_addr};
  assign {h_id, h_wr_n, h_wrap, h_len, h_mask, h_addr} = q_rdata;

  sdrc_sync_fifo #(
    .W     (EW),
    .DEPTH (Q_DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push),
    .wr_data (q_wdata),
    .rd_en   (pop),
    .rd_data (q_rdata),
    .full    (q_full),
    .empty   (q_empty),
    .level   (q_level)
  );

  // Chunk for either the freshly popped head or the remainder after the current chunk.
  always_comb begin
    nxt_addr  = (cur_mask & (cur_addr + AW'(r2b_len))) | (~cur_mask & cur_addr);
    nxt_rem   = rem_len - r2b_len;
    c_addr    = pop ? h_addr : nxt_addr;
    c_rem     = pop ? h_len  : nxt_rem;
    c_wrap    = pop ? h_wrap : r2b_wrap;
    col_w     = 4'(COL_BASE) + {2'b00, cfg_colbits};
    row_sh    = 6'(col_w) + 6'(BA_W);
    col_mask  = (AW'(1) << col_w) - AW'(1);
    c_caddr   = 12'(c_addr & col_mask);
    c_ba      = BA_W'(c_addr >> col_w);
    c_raddr   = RA_W'(c_addr >> row_sh);
    page_full = (PW'(1) << col_w) - PW'(c_caddr);
    page_lim  = PW'(1) << APP_RW;
    page_rem  = (page_full > page_lim) ? LW'(page_lim) : LW'(page_full);
    len_sel   = LW'(c_rem);
    if (!c_wrap && (page_rem < len_sel)) len_sel = page_rem;
    if ((cfg_max_len != '0) && (LW'(cfg_max_len) < len_sel)) len_sel = LW'(cfg_max_len);
    c_len     = APP_RW'(len_sel);
    c_last    = (c_len == c_rem);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= REQ_IDLE;
    else          state <= state_nxt;
  end

  // A push in the same cycle counts as queued work so a lone request reaches bank_ctl two cycles after its ack.
  always_comb begin
    state_nxt = state;
    case (state)
      REQ_IDLE:   if (!q_empty || push) state_nxt = REQ_LOAD;
      REQ_LOAD:   state_nxt = REQ_ACTIVE;
      REQ_ACTIVE: if (b2r_ack && r2b_last) state_nxt = (!q_empty || push) ? REQ_LOAD : REQ_IDLE;
      default:    state_nxt = REQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr   <= '0;
      cur_mask   <= '0;
      rem_len    <= '0;
      r2b_req_id <= '0;
      r2b_start  <= 1'b0;
      r2b_last   <= 1'b0;
      r2b_wrap   <= 1'b0;
      r2b_write  <= 1'b0;
      r2b_ba     <= '0;
      r2b_raddr  <= '0;
      r2b_caddr  <= '0;
      r2b_len    <= '0;
    end else if (pop) begin
      cur_addr   <= h_addr;
      cur_mask   <= h_mask;
      rem_len    <= h_len;
      r2b_req_id <= h_id;
      r2b_start  <= 1'b1;
      r2b_last   <= c_last;
      r2b_wrap   <= h_wrap;
      r2b_write  <= ~h_wr_n;
      r2b_ba     <= c_ba;
      r2b_raddr  <= c_raddr;
      r2b_caddr  <= c_caddr;
      r2b_len    <= c_len;
    end else if (advance) begin
      cur_addr   <= nxt_addr;
      rem_len    <= nxt_rem;
      r2b_start  <= 1'b0;
      r2b_last   <= c_last;
      r2b_ba     <= c_ba;
      r2b_raddr  <= c_raddr;
      r2b_caddr  <= c_caddr;
      r2b_len    <= c_len;
    end
  end

endmodule
